// File: rtl/c3_pool_writeback.sv
// c3_pool_writeback: 2x2 / stride-2 signed max pooling of the raster-ordered C3
// result stream, writing each pooled word to the S4 feature-map buffer.
module c3_pool_writeback #(
    parameter int WIDTH      = 16,
    parameter int CONV_W     = 10,
    parameter int CONV_H     = 10,
    parameter int NUM_MAPS   = 16,
    parameter int MAP_STRIDE = 1024,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              conv_valid_i,
    input  logic [WIDTH-1:0]  conv_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WIDTH-1:0]  wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int COL_W  = (CONV_W > 4) ? $clog2(CONV_W) : 2;
    localparam int ROW_W  = (CONV_H > 2) ? $clog2(CONV_H) : 1;
    localparam int MAP_W  = (NUM_MAPS > 2) ? $clog2(NUM_MAPS) : 1;
    localparam int HALF_W = COL_W - 1;
    localparam int unsigned LB_N = CONV_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [MAP_W-1:0]  map_q;
    logic [WIDTH-1:0]  pair_q;
    logic [WIDTH-1:0]  line_buf [LB_N];

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic              done_q;

    logic              accept;
    logic              col_last, row_last, map_last, last_accept;
    logic [HALF_W-1:0] half_col;
    logic [WIDTH-1:0]  pair_max;
    logic [WIDTH-1:0]  pool_max;
    logic [ADDR_W-1:0] pool_addr;

    function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign accept      = (state_q == ST_RUN) && conv_valid_i;
    assign col_last    = (col_q == COL_W'(CONV_W - 1));
    assign row_last    = (row_q == ROW_W'(CONV_H - 1));
    assign map_last    = (map_q == MAP_W'(NUM_MAPS - 1));
    assign last_accept = accept && col_last && row_last && map_last;
    assign half_col    = col_q[COL_W-1:1];

    // Horizontal pair max, vertical max against the buffered even row, and target address
    always_comb begin
        pair_max  = smax(pair_q, conv_data_i);
        pool_max  = smax(line_buf[half_col], pair_max);
        pool_addr = ADDR_W'(map_q) * ADDR_W'(MAP_STRIDE)
                  + ADDR_W'(row_q >> 1) * ADDR_W'(CONV_W / 2)
                  + ADDR_W'(half_col);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (last_accept) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, pair register, line buffer and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            map_q     <= '0;
            pair_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < LB_N; i++) line_buf[i] <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= (state_q == ST_DONE);
            if ((state_q == ST_IDLE) && start_i) begin
                col_q  <= '0;
                row_q  <= '0;
                map_q  <= '0;
                pair_q <= '0;
            end
            if (accept) begin
                if (!col_q[0]) begin
                    pair_q <= conv_data_i;
                end else if (!row_q[0]) begin
                    line_buf[half_col] <= pair_max;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= pool_max;
                    wr_addr_q <= pool_addr;
                end
                // map counter holds on the final sample so it never wraps within a run
                if (col_last) begin
                    col_q <= '0;
                    if (row_last) begin
                        row_q <= '0;
                        if (!map_last) map_q <= map_q + 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q == ST_RUN);

endmodule

// File: tb/tb_c3_pool_writeback.sv
// Scoreboard bench for c3_pool_writeback: a window-level reference model pushes
// expected writes; a negedge monitor pops and compares them.
module tb_c3_pool_writeback;

    localparam int W  = 16;
    localparam int CW = 10;
    localparam int CH = 10;
    localparam int NM = 16;
    localparam int MS = 1024;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          conv_valid_i;
    logic [W-1:0]  conv_data_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [W-1:0]  wr_data_o;
    logic          busy_o;
    logic          done_o;

    c3_pool_writeback #(
        .WIDTH(W), .CONV_W(CW), .CONV_H(CH), .NUM_MAPS(NM), .MAP_STRIDE(MS), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .conv_valid_i(conv_valid_i),
        .conv_data_i(conv_data_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        int            cyc;
        bit            last;
    } exp_t;

    exp_t q[$];
    int   n_writes = 0;
    int   n_done = 0;
    int   exp_done_cyc = -1;

    // reference model: per-map sample image, pooled window computed from four stored samples
    logic [W-1:0] img [CH][CW];
    bit m_run = 0;
    int m_map, m_row, m_col;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_sample(input logic [W-1:0] d, input int c);
        exp_t e;
        int best;
        img[m_row][m_col] = d;
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            best = sx(img[m_row-1][m_col-1]);
            if (sx(img[m_row-1][m_col]) > best) best = sx(img[m_row-1][m_col]);
            if (sx(img[m_row][m_col-1]) > best) best = sx(img[m_row][m_col-1]);
            if (sx(img[m_row][m_col]) > best)   best = sx(img[m_row][m_col]);
            e.addr = AW'(m_map * MS + (m_row / 2) * (CW / 2) + (m_col / 2));
            e.data = W'(best);
            e.cyc  = c + 1;
            e.last = (m_map == NM - 1) && (m_row == CH - 1) && (m_col == CW - 1);
            q.push_back(e);
        end
        if (m_col == CW - 1) begin
            m_col = 0;
            if (m_row == CH - 1) begin
                m_row = 0;
                m_map++;
            end else m_row++;
        end else m_col++;
        if (m_map == NM) m_run = 0;
    endtask

    // one input cycle: update the model with what the DUT should accept, then clock it
    task automatic drive(input bit s, input bit v, input logic [W-1:0] d);
        start_i = s;
        conv_valid_i = v;
        conv_data_i = d;
        if (v && m_run) model_sample(d, cyc);
        if (s && !m_run) begin
            m_run = 1; m_map = 0; m_row = 0; m_col = 0;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        conv_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, W'($urandom));
    endtask

    function automatic logic [W-1:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic wait_drain(input int want_done);
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && n_done == want_done) break;
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // monitor: every write must match the head of the scoreboard, cycle-exact
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_o) begin
                n_writes++;
                if (q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_addr", wr_addr_o, e.addr);
                    chk("wr_data", wr_data_o, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                    if (e.last) exp_done_cyc = e.cyc + 1;
                end
            end
            if (done_o || cyc == exp_done_cyc) begin
                chk("done_o", done_o, 1);
                chk("done_cycle", cyc, exp_done_cyc);
                chk("busy_in_done", busy_o, 0);
                if (done_o) n_done++;
            end
        end
    end

    initial begin
        logic [W-1:0] win_tab [2][4];
        win_tab[0][0] = 16'h8000; win_tab[0][1] = 16'hFFFF;
        win_tab[1][0] = 16'h8001; win_tab[1][1] = 16'hFFFE;
        win_tab[0][2] = 16'h7FFF; win_tab[0][3] = 16'h0000;
        win_tab[1][2] = 16'h8000; win_tab[1][3] = 16'h0001;

        rst = 1'b1; start_i = 1'b0; conv_valid_i = 1'b0; conv_data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_wr_en", wr_en_o, 0);
        chk("reset_wr_addr", wr_addr_o, 0);
        chk("reset_wr_data", wr_data_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        @(posedge clk); #1;

        // valid while idle before any start: dropped
        drive(0, 1, 16'h1234);
        drive(0, 1, 16'h7FFF);

        // full run: map0 ramp, map1 signed windows, rest random with gaps
        n_writes = 0;
        drive(1, 0, '0);
        chk("busy_after_start", busy_o, 1);
        for (int mp = 0; mp < NM; mp++)
            for (int r = 0; r < CH; r++)
                for (int c = 0; c < CW; c++) begin
                    if (mp == 0) drive(0, 1, W'(r * 10 + c));
                    else begin
                        if (mp == 1 && r < 2 && c < 4) drive(0, 1, win_tab[r][c]);
                        else drive(0, 1, rnd16());
                        idle($urandom_range(0, 3));
                    end
                    // a second start mid-run must not restart anything
                    if (mp == 3 && r == 4 && c == 5) drive(1, 0, '0);
                end
        // valid pulses while in DONE and IDLE: dropped
        for (int i = 0; i < 5; i++) drive(0, 1, rnd16());
        wait_drain(1);
        chk("run1_writes", n_writes, (CW / 2) * (CH / 2) * NM);
        chk("run1_done_count", n_done, 1);
        chk("idle_busy", busy_o, 0);

        // second run: start with coincident valid, mid-run start, then reset after 57 samples
        drive(1, 1, 16'h7FFF);
        for (int i = 0; i < 57; i++) drive((i == 20), 1, rnd16());
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        m_run = 0;
        @(negedge clk);
        chk("abort_wr_en", wr_en_o, 0);
        chk("abort_wr_addr", wr_addr_o, 0);
        chk("abort_wr_data", wr_data_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        @(posedge clk); #1 rst = 1'b0;

        // third run: clean map0 ramp after abort
        n_writes = 0;
        drive(1, 0, '0);
        for (int r = 0; r < CH; r++)
            for (int c = 0; c < CW; c++) drive(0, 1, W'(r * 10 + c));
        idle(5);
        wait_drain(1);
        chk("run3_map0_writes", n_writes, (CW / 2) * (CH / 2));
        chk("run3_no_done", n_done, 1);
        chk("run3_busy", busy_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
